// File: rtl/elastic_pipe_chain_pkg.sv
// Shared widths and slot control encoding for the elastic pipeline chain.
// Data forwarding is enabled by defining PIPE_FWD_EN at build time.
package elastic_pipe_chain_pkg;

  localparam int CPU_WIDTH      = 64;
  localparam int REG_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    SlotHold,
    SlotLoad,
    SlotClear
  } slot_op_e;

endpackage

// File: rtl/pipe_slot.sv
// One elastic pipeline stage register: valid, payload, destination tag and write enable.
// A load of a bubble clears valid but keeps the previous payload/tag/wen.
module pipe_slot
  import elastic_pipe_chain_pkg::*;
#(
  parameter int DATA_W = CPU_WIDTH,
  parameter int TAG_W  = REG_ADDR_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              in_wen,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [TAG_W-1:0]  tag,
  output logic              wen
);

  slot_op_e          op;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              wen_q, wen_d;

  always_comb begin
    op = SlotHold;
    if (load) begin
      op = SlotLoad;
    end else if (clear) begin
      op = SlotClear;
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    tag_d   = tag_q;
    wen_d   = wen_q;
    unique case (op)
      SlotLoad: begin
        valid_d = in_valid;
        if (in_valid) begin
          data_d = in_data;
          tag_d  = in_tag;
          wen_d  = in_wen;
        end
      end
      SlotClear: valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      tag_q   <= '0;
      wen_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
      wen_q   <= wen_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign tag   = tag_q;
  assign wen   = wen_q;

endmodule

// File: rtl/elastic_pipe_chain.sv
// Elastic valid/ready register chain with per-stage flush and destination-tag hazard lookup.
// Define PIPE_FWD_EN to build the youngest-match forwarding mux (q_hit/q_data).
module elastic_pipe_chain
  import elastic_pipe_chain_pkg::*;
#(
  parameter int DATA_W = CPU_WIDTH,
  parameter int TAG_W  = REG_ADDR_WIDTH,
  parameter int STAGES = 3,
  parameter int CNT_W  = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              in_wen,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_wen,
  input  logic [STAGES:0]   flush_vec,
  input  logic [TAG_W-1:0]  q_tag,
  output logic              q_busy,
  output logic              q_hit,
  output logic [DATA_W-1:0] q_data,
  output logic [CNT_W-1:0]  occ
);

  if (STAGES < 1) begin : g_bad_cfg
    $error("elastic_pipe_chain: STAGES must be at least 1");
  end

  logic [STAGES:1]   v;
  logic [STAGES:1]   wen_r;
  logic [DATA_W-1:0] data_r [1:STAGES];
  logic [TAG_W-1:0]  tag_r  [1:STAGES];

  logic [STAGES:0]   ev;
  logic [STAGES+1:1] r;
  logic [STAGES:1]   match;
  logic [CNT_W-1:0]  occ_cnt;

  always_comb begin
    ev[0] = in_valid & ~flush_vec[0];
    for (int i = 1; i <= STAGES; i++) begin
      ev[i] = v[i] & ~flush_vec[i];
    end
  end

  // A stage can take a beat if it is effectively empty or its own beat moves on.
  always_comb begin
    r           = '0;
    r[STAGES+1] = out_ready;
    for (int i = STAGES; i >= 1; i--) begin
      r[i] = ~ev[i] | r[i+1];
    end
  end

  assign in_ready = r[1] | flush_vec[0];

  for (genvar i = 1; i <= STAGES; i++) begin : g_slot
    logic [DATA_W-1:0] src_data;
    logic [TAG_W-1:0]  src_tag;
    logic              src_wen;

    if (i == 1) begin : g_head
      assign src_data = in_data;
      assign src_tag  = in_tag;
      assign src_wen  = in_wen;
    end else begin : g_body
      assign src_data = data_r[i-1];
      assign src_tag  = tag_r[i-1];
      assign src_wen  = wen_r[i-1];
    end

    pipe_slot #(
      .DATA_W(DATA_W),
      .TAG_W (TAG_W)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .load    (r[i]),
      .clear   (flush_vec[i]),
      .in_valid(ev[i-1]),
      .in_data (src_data),
      .in_tag  (src_tag),
      .in_wen  (src_wen),
      .valid   (v[i]),
      .data    (data_r[i]),
      .tag     (tag_r[i]),
      .wen     (wen_r[i])
    );
  end

  assign out_valid = ev[STAGES];
  assign out_data  = data_r[STAGES];
  assign out_tag   = tag_r[STAGES];
  assign out_wen   = wen_r[STAGES];

  // Tag 0 is the hardwired zero register and never creates a hazard.
  always_comb begin
    for (int i = 1; i <= STAGES; i++) begin
      match[i] = ev[i] & wen_r[i] & (tag_r[i] == q_tag) & (q_tag != '0);
    end
  end

  assign q_busy = |match;

`ifdef PIPE_FWD_EN
  logic [DATA_W-1:0] fwd_data;

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    fwd_data = '0;
    for (int i = STAGES; i >= 1; i--) begin
      if (match[i]) begin
        fwd_data = data_r[i];
      end
    end
  end

  assign q_hit  = q_busy;
  assign q_data = fwd_data;
`else
  assign q_hit  = 1'b0;
  assign q_data = '0;
`endif

  always_comb begin
    occ_cnt = '0;
    for (int i = 1; i <= STAGES; i++) begin
      occ_cnt = occ_cnt + CNT_W'(v[i]);
    end
  end

  assign occ = occ_cnt;

endmodule

// File: tb/tb_elastic_pipe_chain.sv
// Randomised and directed bench for elastic_pipe_chain against a slot-list reference model.
module tb_elastic_pipe_chain;

  localparam int STAGES = 3;
  localparam int DATA_W = 64;
  localparam int TAG_W  = 5;
  localparam int CNT_W  = 2;
`ifdef PIPE_FWD_EN
  localparam bit FwdEn = 1'b1;
`else
  localparam bit FwdEn = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [TAG_W-1:0]  in_tag = '0;
  logic              in_wen = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;
  logic              out_wen;
  logic [STAGES:0]   flush_vec = '0;
  logic [TAG_W-1:0]  q_tag = '0;
  logic              q_busy;
  logic              q_hit;
  logic [DATA_W-1:0] q_data;
  logic [CNT_W-1:0]  occ;

  elastic_pipe_chain #(
    .DATA_W(DATA_W),
    .TAG_W (TAG_W),
    .STAGES(STAGES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_tag   (in_tag),
    .in_wen   (in_wen),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_tag  (out_tag),
    .out_wen  (out_wen),
    .flush_vec(flush_vec),
    .q_tag    (q_tag),
    .q_busy   (q_busy),
    .q_hit    (q_hit),
    .q_data   (q_data),
    .occ      (occ)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int first_acc, first_ov;
  bit last_fire;
  logic [DATA_W-1:0] out_log [$];
  int                out_cyc [$];

  // Reference model: list of slots, index 1 youngest .. STAGES oldest.
  bit                mv [1:STAGES];
  logic [DATA_W-1:0] md [1:STAGES];
  logic [TAG_W-1:0]  mt [1:STAGES];
  bit                mw [1:STAGES];

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  function automatic bit m_live(int i);
    return mv[i] && !flush_vec[i];
  endfunction

  task automatic model_reset();
    for (int i = 1; i <= STAGES; i++) begin
      mv[i] = 0; md[i] = '0; mt[i] = '0; mw[i] = 0;
    end
  endtask

  task automatic compare_model();
    bit exp_ready, busy;
    int cnt;
    logic [63:0] fwd;
    // Input is taken if it is flushed, the tail drains, or any slot is free.
    exp_ready = flush_vec[0] || out_ready;
    cnt = 0; busy = 0; fwd = '0;
    for (int i = 1; i <= STAGES; i++) begin
      if (!m_live(i)) exp_ready = 1;
      if (mv[i]) cnt++;
    end
    for (int i = STAGES; i >= 1; i--) begin
      if (m_live(i) && mw[i] && mt[i] == q_tag && q_tag != 0) begin
        busy = 1;
        fwd  = md[i];
      end
    end
    check_eq("in_ready", 64'(in_ready), 64'(exp_ready));
    check_eq("out_valid", 64'(out_valid), 64'(m_live(STAGES)));
    check_eq("occ", 64'(occ), 64'(cnt));
    check_eq("q_busy", 64'(q_busy), 64'(busy));
    check_eq("q_hit", 64'(q_hit), 64'(busy & FwdEn));
    check_eq("q_data", q_data, FwdEn ? fwd : 64'(0));
    if (m_live(STAGES)) begin
      check_eq("out_data", out_data, md[STAGES]);
      check_eq("out_tag", 64'(out_tag), 64'(mt[STAGES]));
      check_eq("out_wen", 64'(out_wen), 64'(mw[STAGES]));
    end
  endtask

  task automatic model_step();
    for (int i = 1; i <= STAGES; i++) if (flush_vec[i]) mv[i] = 0;
    if (mv[STAGES] && out_ready) mv[STAGES] = 0;
    // Each beat advances at most one slot per cycle, into a slot left empty.
    for (int i = STAGES; i >= 2; i--) begin
      if (!mv[i] && mv[i-1]) begin
        mv[i] = 1; md[i] = md[i-1]; mt[i] = mt[i-1]; mw[i] = mw[i-1];
        mv[i-1] = 0;
      end
    end
    if (!mv[1] && in_valid && !flush_vec[0]) begin
      mv[1] = 1; md[1] = in_data; mt[1] = in_tag; mw[1] = in_wen;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    compare_model();
    last_fire = in_valid && in_ready;
    if (last_fire && first_acc < 0) first_acc = cyc;
    if (out_valid && first_ov < 0) first_ov = cyc;
    if (out_valid && out_ready) begin
      out_log.push_back(out_data);
      out_cyc.push_back(cyc);
    end
    @(posedge clk);
    model_step();
    #1;
    cyc++;
  endtask

  task automatic push(input logic [63:0] d, input logic [4:0] t, input bit w);
    bit took = 0;
    in_valid = 1; in_data = d; in_tag = t; in_wen = w;
    for (int k = 0; k < 20 && !took; k++) begin
      cycle();
      took = last_fire;
    end
    in_valid = 0;
    check_eq("push_accept", 64'(took), 64'(1));
  endtask

  task automatic drain(input int n);
    in_valid = 0; flush_vec = '0; out_ready = 1;
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    model_reset();
    #3;
    check_eq("rst_out_valid", 64'(out_valid), 64'(0));
    check_eq("rst_occ", 64'(occ), 64'(0));
    check_eq("rst_q_busy", 64'(q_busy), 64'(0));
    check_eq("rst_q_hit", 64'(q_hit), 64'(0));
    check_eq("rst_q_data", q_data, 64'(0));
    check_eq("rst_out_data", out_data, 64'(0));
    check_eq("rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    @(posedge clk);
    #1 rst = 0;

    // Stream 1..8 with the sink always ready.
    out_ready = 1; first_acc = -1; first_ov = -1;
    out_log.delete(); out_cyc.delete();
    for (int k = 1; k <= 8; k++) push(64'(k), 5'(k), 1'b1);
    drain(6);
    check_eq("stream_latency", 64'(first_ov - first_acc), 64'(STAGES));
    check_eq("stream_count", 64'(out_log.size()), 64'(8));
    if (out_log.size() == 8) begin
      check_eq("stream_span", 64'(out_cyc[7] - out_cyc[0]), 64'(7));
      for (int k = 0; k < 8; k++) check_eq("stream_order", out_log[k], 64'(k + 1));
    end

    // Backpressure: four offered into a stalled chain, three fit.
    out_ready = 0; acc = 0; in_valid = 1; in_tag = 5'd9; in_wen = 1;
    for (int k = 0; k < 4; k++) begin
      in_data = 64'(100 + acc);
      cycle();
      if (last_fire) acc++;
    end
    check_eq("bp_accepted", 64'(acc), 64'(3));
    check_eq("bp_in_ready", 64'(in_ready), 64'(0));
    check_eq("bp_occ", 64'(occ), 64'(3));
    out_ready = 1;
    out_log.delete(); out_cyc.delete();
    cycle();
    check_eq("bp_full_accept", 64'(last_fire), 64'(1));
    drain(5);
    check_eq("bp_count", 64'(out_log.size()), 64'(4));
    if (out_log.size() == 4) begin
      for (int k = 0; k < 4; k++) check_eq("bp_order", out_log[k], 64'(100 + k));
      check_eq("bp_no_gap", 64'(out_cyc[3] - out_cyc[0]), 64'(3));
    end

    // Bubble collapse behind a stalled tail.
    out_ready = 0;
    push(64'h21, 5'd1, 1'b1);
    cycle();
    push(64'h22, 5'd2, 1'b1);
    check_eq("bubble_in_ready", 64'(in_ready), 64'(1));
    check_eq("bubble_occ", 64'(occ), 64'(2));
    cycle();
    push(64'h23, 5'd3, 1'b1);
    check_eq("bubble_full_occ", 64'(occ), 64'(3));
    check_eq("bubble_full_ready", 64'(in_ready), 64'(0));
    drain(5);

    // Flush the two younger stages of a full chain.
    out_ready = 0;
    push(64'h31, 5'd1, 1'b0);
    push(64'h32, 5'd2, 1'b0);
    push(64'h33, 5'd3, 1'b0);
    flush_vec = 4'b0110;
    #1;
    check_eq("flush_out_valid", 64'(out_valid), 64'(1));
    check_eq("flush_out_data", out_data, 64'h31);
    cycle();
    flush_vec = '0;
    #1;
    check_eq("flush_occ", 64'(occ), 64'(1));
    out_log.delete(); out_cyc.delete();
    drain(5);
    check_eq("flush_count", 64'(out_log.size()), 64'(1));
    if (out_log.size() == 1) check_eq("flush_survivor", out_log[0], 64'h31);

    // Forwarding: youngest of two writers to r5 wins.
    out_ready = 0;
    push(64'hBB, 5'd5, 1'b1);
    push(64'hCC, 5'd7, 1'b1);
    push(64'hAA, 5'd5, 1'b1);
    q_tag = 5'd5;
    #1;
    check_eq("fwd_busy", 64'(q_busy), 64'(1));
    check_eq("fwd_hit", 64'(q_hit), 64'(FwdEn));
    check_eq("fwd_data", q_data, FwdEn ? 64'hAA : 64'h0);
    q_tag = 5'd0;
    #1;
    check_eq("fwd_r0_busy", 64'(q_busy), 64'(0));
    check_eq("fwd_r0_hit", 64'(q_hit), 64'(0));
    check_eq("fwd_r0_data", q_data, 64'h0);
    drain(5);

    // Randomised traffic with flushes and hazard queries.
    for (int k = 0; k < 600; k++) begin
      in_valid  = 1'($urandom % 2);
      in_data   = {$urandom, $urandom};
      in_tag    = 5'($urandom % 4);
      in_wen    = 1'($urandom % 2);
      out_ready = ($urandom % 4) != 0;
      flush_vec = ($urandom % 8 == 0) ? 4'($urandom % 16) : 4'b0;
      q_tag     = 5'($urandom % 4);
      cycle();
    end
    drain(5);

    // Asynchronous reset in the middle of a stream.
    push(64'h51, 5'd1, 1'b1);
    push(64'h52, 5'd2, 1'b1);
    #2 rst = 1;
    #1;
    check_eq("midrst_out_valid", 64'(out_valid), 64'(0));
    check_eq("midrst_occ", 64'(occ), 64'(0));
    check_eq("midrst_out_data", out_data, 64'h0);
    model_reset();
    @(posedge clk);
    #1 rst = 0;
    first_acc = -1; first_ov = -1;
    push(64'h77, 5'd7, 1'b1);
    for (int k = 0; k < 10 && first_ov < 0; k++) cycle();
    check_eq("midrst_first_acc", 64'(first_acc >= 0), 64'(1));
    check_eq("midrst_latency", 64'(first_ov - first_acc), 64'(STAGES));
    drain(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/elastic_pipe_chain.md
# elastic_pipe_chain

Parametrised elastic pipeline register chain with valid/ready handshaking, per-stage flush and destination-tag hazard lookup. It generalises the fixed IF/ID/EX/MEM/WB stage registers into one block with configurable payload width and stage count. Bubbles collapse, so a stall at the tail only back-pressures as far as needed. It is the building block for the next core revision's issue-to-writeback path, and it feeds the decode stage's stall and forwarding decisions.

## Interface
- `DATA_W`, default 64: payload width.
- `TAG_W`, default 5: destination register address width.
- `STAGES`, default 3: number of register stages, minimum 1.
- `CNT_W`, default `$clog2(STAGES+1)`: width of the occupancy count.

- `clk`, in, 1: clock. All state updates on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: upstream beat present.
- `in_ready`, out, 1: beat accepted this cycle.
- `in_data`, in, DATA_W: payload.
- `in_tag`, in, TAG_W: destination register.
- `in_wen`, in, 1: beat writes its destination register.
- `out_valid`, out, 1: oldest stage holds a beat.
- `out_ready`, in, 1: downstream accepts.
- `out_data`, out, DATA_W: payload of the oldest stage.
- `out_tag`, out, TAG_W: tag of the oldest stage.
- `out_wen`, out, 1: write enable of the oldest stage.
- `flush_vec`, in, STAGES+1: bit 0 kills the input beat; bit i kills stage i.
- `q_tag`, in, TAG_W: hazard query tag.
- `q_busy`, out, 1: a live in-flight writer matches `q_tag`.
- `q_hit`, out, 1: forwarding data is valid.
- `q_data`, out, DATA_W: forwarded payload.
- `occ`, out, CNT_W: count of valid stage registers.

## Operation
- Stages are numbered 1 (youngest) to STAGES (oldest). Stage STAGES drives the `out_*` ports.
- Effective valid: `ev[i] = v[i] & ~flush_vec[i]`.
- Ready chain:
  - `r[STAGES+1] = out_ready`.
  - `r[i] = ~ev[i] | r[i+1]`.
  - `in_ready = r[1] | flush_vec[0]`.
- Stage i loads from stage i-1 when `r[i]` is high; stage 0 is the input, with `ev[0] = in_valid & ~flush_vec[0]`. The loaded valid is `ev[i-1]`.
- A stage whose contents leave and that receives nothing goes to valid 0. Its data register holds its old value.
- A flushed stage never propagates. Its valid is 0 after the edge unless it loads a new beat from below.
- With `flush_vec[0]` high, an input beat is consumed (handshake completes) and discarded.
- `out_valid = ev[STAGES]`. A flushed oldest stage is never presented.
- Hazard lookup:
  - A stage matches when `ev[i] & wen[i] & (tag[i] == q_tag) & (q_tag != 0)`.
  - `q_busy` is the OR of all matches.
  - The youngest matching stage wins, and its data drives `q_data`.
- `occ` is the popcount of the registered `v[]`, before flush.
- Reset: all `v` = 0; data, tag and wen registers = 0; `out_valid`, `q_busy`, `q_hit` and `occ` = 0; `q_data` = 0.

## Timing
- Minimum latency is STAGES cycles from input acceptance to `out_valid`, with `out_ready` held high.
- Throughput is one beat per cycle.
- `in_ready`, `q_*` and `out_valid` are combinational from the registers, `out_ready` and `flush_vec`.
  - The path from `out_ready` to `in_ready` runs through STAGES levels.
  - There is no combinational path from `in_valid` to `in_ready`.
- Full: with all `ev` set and `out_ready` = 0, `in_ready` = 0 and contents hold.
- When `out_ready` and `in_valid` rise in the same cycle as full, every stage shifts and the new beat is accepted.
- Reset asserted mid-stream clears everything immediately. The first acceptance is possible in the cycle after deassertion.

## Configuration
- `PIPE_FWD_EN` defined: `q_hit = q_busy`, and `q_data` is the youngest match's payload.
- `PIPE_FWD_EN` undefined:
  - `q_hit` and `q_data` are tied to 0 and the data mux is not built.
  - `q_busy` remains, so the consumer stalls instead of forwarding.

## Structure
- Shared defines file: default widths (`CPU_WIDTH`, `REG_ADDR_WIDTH`) and the `PIPE_FWD_EN` switch.
- Sub-module `pipe_slot`: one stage register holding valid, data, tag and wen, with load and clear controls. It is instantiated STAGES times with a generate loop.
- Ready chain, flush gating, match priority encoder and popcount live in the top module.

## Test plan
All scenarios use STAGES=3, DATA_W=64 and TAG_W=5.
- Stream: push data 1..8 with `out_ready`=1 → first `out_valid` 3 cycles after first accept, then data 1..8 in order on consecutive cycles.
- Backpressure: `out_ready`=0, offer 4 beats → 3 accepted, `in_ready`=0, `occ`=3. Raise `out_ready` → outputs 1, 2, 3, 4 with no gaps.
- Bubble collapse: stage 3 is stalled with stage 1 valid and stage 2 empty, then one cycle later stage 1's beat sits in stage 2 while `in_ready` stays 1.
- Flush: all 3 stages full, `flush_vec`=4'b0110 → `out_valid` stays 1 for stage 3. After the edge, `occ`=1 (stages 1 and 2 are empty). Killed beats never appear on the output.
- Forward:
  - Stage 1 holds tag 5 / 0xAA with wen, and stage 3 holds tag 5 / 0xBB. With `q_tag`=5 → `q_busy`=1, `q_hit`=1, `q_data`=0xAA.
  - With `q_tag`=0 → all three outputs are 0.
  - With `PIPE_FWD_EN` undefined → `q_hit`=0 while `q_busy`=1.
- Reset mid-stream: after 2 accepts, pulse `rst` asynchronously → `out_valid`=0 and `occ`=0 before the next edge. The next beat has latency 3.
